// File: rtl/opb_master_pkg.sv
// Shared constants for the single-master OPB bridge: parameter defaults,
// FSM state encodings and response status codes.
package opb_master_pkg;

  localparam int unsigned DEF_OPB_AWIDTH = 32;
  localparam int unsigned DEF_OPB_DWIDTH = 32;
  localparam int unsigned DEF_TIMEOUT    = 16;
  localparam int unsigned DEF_MAX_RETRY  = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] RSP_OK              = 2'd0;
  localparam logic [1:0] RSP_ERRACK          = 2'd1;
  localparam logic [1:0] RSP_TIMEOUT         = 2'd2;
  localparam logic [1:0] RSP_RETRY_EXHAUSTED = 2'd3;

endpackage

// File: rtl/opb_bit_reverse.sv
// Maps a little-endian [W-1:0] vector onto an MSB-first [0:W-1] bus vector
// so that bus bit 0 carries the most significant bit.
module opb_bit_reverse #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  output logic [0:W-1] y
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign y[i] = a[W-1-i];
  end

endmodule

// File: rtl/opb_single_master.sv
// Single-master OPB bridge: accepts one command at a time, arbitrates for the
// bus, runs the transfer with retry/timeout handling and returns one response.
module opb_single_master
  import opb_master_pkg::*;
#(
  parameter int unsigned C_OPB_AWIDTH = DEF_OPB_AWIDTH,
  parameter int unsigned C_OPB_DWIDTH = DEF_OPB_DWIDTH,
  parameter int unsigned C_TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned C_MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rnw,
  input  logic [C_OPB_AWIDTH-1:0]     cmd_addr,
  input  logic [C_OPB_DWIDTH/8-1:0]   cmd_be,
  input  logic [C_OPB_DWIDTH-1:0]     cmd_wdata,
  output logic                        rsp_valid,
  output logic [C_OPB_DWIDTH-1:0]     rsp_rdata,
  output logic [1:0]                  rsp_status,
  output logic                        M_request,
  input  logic                        OPB_MGrant,
  output logic                        M_select,
  output logic                        M_RNW,
  output logic [0:C_OPB_AWIDTH-1]     M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
  output logic [0:C_OPB_DWIDTH-1]     M_DBus,
  output logic                        M_seqAddr,
  output logic                        M_busLock,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_xferAck,
  input  logic                        OPB_errAck,
  input  logic                        OPB_retry,
  input  logic                        OPB_toutSup
);

  localparam int unsigned BW = C_OPB_DWIDTH / 8;
  localparam int unsigned TW = $clog2(C_TIMEOUT + 1);
  localparam int unsigned RW = $clog2(C_MAX_RETRY + 1);

  logic [1:0]              state;
  logic                    rnw_q;
  logic [C_OPB_AWIDTH-1:0] addr_q;
  logic [BW-1:0]           be_q;
  logic [C_OPB_DWIDTH-1:0] wdata_q;
  logic [C_OPB_DWIDTH-1:0] rdata_q;
  logic [1:0]              status_q;
  logic [TW-1:0]           tout_cnt;
  logic [RW-1:0]           retry_cnt;

  logic [0:C_OPB_AWIDTH-1] abus_rev;
  logic [0:BW-1]           be_rev;
  logic [0:C_OPB_DWIDTH-1] wbus_rev;
  logic [C_OPB_DWIDTH-1:0] rdata_in;
  logic                    sel;

  opb_bit_reverse #(.W(C_OPB_AWIDTH)) u_addr_rev  (.a(addr_q),   .y(abus_rev));
  opb_bit_reverse #(.W(BW))           u_be_rev    (.a(be_q),     .y(be_rev));
  opb_bit_reverse #(.W(C_OPB_DWIDTH)) u_wdata_rev (.a(wdata_q),  .y(wbus_rev));
  // Read direction: the ascending bus vector feeds the descending input, so the
  // positional port binding plus the reversal yields rdata_in[31] = OPB_DBus[0].
  opb_bit_reverse #(.W(C_OPB_DWIDTH)) u_rdata_rev (.a(OPB_DBus), .y(rdata_in));

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state     <= ST_IDLE;
      rnw_q     <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      status_q  <= RSP_OK;
      tout_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            rnw_q     <= cmd_rnw;
            addr_q    <= cmd_addr;
            be_q      <= cmd_be;
            wdata_q   <= cmd_wdata;
            retry_cnt <= '0;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          tout_cnt <= '0;
          if (OPB_MGrant) state <= ST_XFER;
        end
        ST_XFER: begin
          // errAck beats xferAck, which beats retry; a silent slave times out.
          if (OPB_errAck) begin
            status_q <= RSP_ERRACK;
            state    <= ST_RESP;
          end else if (OPB_xferAck) begin
            status_q <= RSP_OK;
            rdata_q  <= rnw_q ? rdata_in : '0;
            state    <= ST_RESP;
          end else if (OPB_retry) begin
            tout_cnt <= '0;
            if (retry_cnt < RW'(C_MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ST_REQ;
            end else begin
              status_q <= RSP_RETRY_EXHAUSTED;
              state    <= ST_RESP;
            end
          end else if (OPB_toutSup) begin
            tout_cnt <= '0;
          end else if (tout_cnt == TW'(C_TIMEOUT - 1)) begin
            status_q <= RSP_TIMEOUT;
            state    <= ST_RESP;
          end else begin
            tout_cnt <= tout_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sel        = (state == ST_XFER);
  assign cmd_ready  = OPB_Rst_n & (state == ST_IDLE);
  assign M_request  = (state == ST_REQ);
  assign M_select   = sel;
  assign M_RNW      = sel & rnw_q;
  assign M_ABus     = sel ? abus_rev : '0;
  assign M_BE       = sel ? be_rev : '0;
  assign M_DBus     = (sel && !rnw_q) ? wbus_rev : '0;
  assign M_seqAddr  = 1'b0;
  assign M_busLock  = 1'b0;
  assign rsp_valid  = (state == ST_RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_status = status_q;

endmodule

// File: tb/tb_opb_single_master.sv
// Directed self-checking bench for opb_single_master; the bench plays the
// arbiter and slave and checks bus signals and responses cycle by cycle.
module tb_opb_single_master;

  logic        OPB_Clk;
  logic        OPB_Rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rnw;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        M_request;
  logic        OPB_MGrant;
  logic        M_select;
  logic        M_RNW;
  logic [0:31] M_ABus;
  logic [0:3]  M_BE;
  logic [0:31] M_DBus;
  logic        M_seqAddr;
  logic        M_busLock;
  logic [0:31] OPB_DBus;
  logic        OPB_xferAck;
  logic        OPB_errAck;
  logic        OPB_retry;
  logic        OPB_toutSup;

  int vectors;
  int miscompares;
  int sel_cycles;
  int sel_phases;

  opb_single_master #(
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_TIMEOUT(16),
    .C_MAX_RETRY(8)
  ) dut (
    .OPB_Clk(OPB_Clk),
    .OPB_Rst_n(OPB_Rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr),
    .cmd_be(cmd_be),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status),
    .M_request(M_request),
    .OPB_MGrant(OPB_MGrant),
    .M_select(M_select),
    .M_RNW(M_RNW),
    .M_ABus(M_ABus),
    .M_BE(M_BE),
    .M_DBus(M_DBus),
    .M_seqAddr(M_seqAddr),
    .M_busLock(M_busLock),
    .OPB_DBus(OPB_DBus),
    .OPB_xferAck(OPB_xferAck),
    .OPB_errAck(OPB_errAck),
    .OPB_retry(OPB_retry),
    .OPB_toutSup(OPB_toutSup)
  );

  initial OPB_Clk = 1'b0;
  always #5 OPB_Clk = ~OPB_Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge OPB_Clk);
  endtask

  task automatic slave_idle();
    OPB_MGrant  = 1'b0;
    OPB_xferAck = 1'b0;
    OPB_errAck  = 1'b0;
    OPB_retry   = 1'b0;
    OPB_toutSup = 1'b0;
  endtask

  // Offer a command in cycle 0; returns at the negedge of cycle 1 (REQ).
  task automatic issue(input logic rnw, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata);
    check("accept_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_rnw   = rnw;
    cmd_addr  = addr;
    cmd_be    = be;
    cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_to_select(input int bound);
    int n = 0;
    while (!M_select && n < bound) begin
      tick();
      n++;
    end
    if (!M_select) check("select_wait", M_select, 1);
  endtask

  task automatic wait_rsp(input int bound, output int cycles, output int phases);
    int   n = 0;
    logic prev;
    cycles = 0;
    phases = 0;
    prev   = M_select;
    while (!rsp_valid && n < bound) begin
      tick();
      n++;
      if (M_select) begin
        cycles++;
        if (!prev) phases++;
      end
      prev = M_select;
    end
    if (!rsp_valid) check("rsp_wait", rsp_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    OPB_Rst_n   = 1'b0;
    cmd_valid   = 1'b0;
    cmd_rnw     = 1'b0;
    cmd_addr    = '0;
    cmd_be      = '0;
    cmd_wdata   = '0;
    OPB_DBus    = '0;
    slave_idle();

    // Reset state
    tick();
    tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_request", M_request, 0);
    check("rst_select", M_select, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_dbus", M_DBus, 0);
    OPB_Rst_n = 1'b1;
    tick();
    check("post_rst_ready", cmd_ready, 1);

    // Write with immediate grant and ack: request c1, select c2, response c3
    OPB_MGrant  = 1'b1;
    OPB_xferAck = 1'b1;
    issue(1'b0, 32'h0101_4800, 4'hF, 32'hDEAD_BEEF);
    check("wr_c1_request", M_request, 1);
    check("wr_c1_select", M_select, 0);
    tick();
    check("wr_c2_select", M_select, 1);
    check("wr_c2_request", M_request, 0);
    check("wr_c2_rnw", M_RNW, 0);
    check("wr_c2_abus", M_ABus, 32'h0101_4800);
    check("wr_c2_be", M_BE, 4'hF);
    check("wr_c2_dbus", M_DBus, 32'hDEAD_BEEF);
    tick();
    check("wr_c3_rsp_valid", rsp_valid, 1);
    check("wr_c3_status", rsp_status, 0);
    check("wr_c3_rdata", rsp_rdata, 0);
    check("wr_c3_select", M_select, 0);
    slave_idle();
    tick();
    check("wr_rsp_one_cycle", rsp_valid, 0);
    check("wr_back_idle", cmd_ready, 1);

    // Read returning 0x12345678
    OPB_MGrant  = 1'b1;
    OPB_xferAck = 1'b1;
    OPB_DBus    = 32'h1234_5678;
    issue(1'b1, 32'h0101_4804, 4'hF, 32'hFFFF_FFFF);
    tick();
    check("rd_select", M_select, 1);
    check("rd_rnw", M_RNW, 1);
    check("rd_abus", M_ABus, 32'h0101_4804);
    check("rd_dbus_zero", M_DBus, 0);
    tick();
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_status", rsp_status, 0);
    check("rd_rdata", rsp_rdata, 32'h1234_5678);
    slave_idle();
    tick();

    // Silent slave: timeout after 16 select cycles, read data held
    OPB_MGrant = 1'b1;
    OPB_DBus   = 32'hFFFF_FFFF;
    issue(1'b1, 32'h0000_0100, 4'hF, 32'h0);
    wait_rsp(100, sel_cycles, sel_phases);
    check("to_sel_cycles", sel_cycles, 16);
    check("to_status", rsp_status, 2);
    check("to_rdata_held", rsp_rdata, 32'h1234_5678);
    slave_idle();
    tick();

    // Timeout suppressed for 40 cycles, then ack
    OPB_MGrant  = 1'b1;
    OPB_toutSup = 1'b1;
    issue(1'b1, 32'h0000_0200, 4'h3, 32'h0);
    run_to_select(10);
    repeat (40) tick();
    check("tsup_select_held", M_select, 1);
    check("tsup_no_rsp", rsp_valid, 0);
    OPB_DBus    = 32'hCAFE_F00D;
    OPB_xferAck = 1'b1;
    tick();
    check("tsup_rsp_valid", rsp_valid, 1);
    check("tsup_status", rsp_status, 0);
    check("tsup_rdata", rsp_rdata, 32'hCAFE_F00D);
    slave_idle();
    tick();

    // Retry on every attempt: 9 select phases, then exhausted
    OPB_MGrant = 1'b1;
    OPB_retry  = 1'b1;
    issue(1'b0, 32'h0000_0300, 4'hF, 32'h5555_AAAA);
    wait_rsp(300, sel_cycles, sel_phases);
    check("rty_phases", sel_phases, 9);
    check("rty_status", rsp_status, 3);
    check("rty_rdata_held", rsp_rdata, 32'hCAFE_F00D);
    slave_idle();
    tick();

    // Grant withheld in REQ, then xferAck with retry counts as OK
    issue(1'b0, 32'h0000_0304, 4'h1, 32'h0F0F_0F0F);
    repeat (3) begin
      tick();
      check("nogrant_request", M_request, 1);
      check("nogrant_select", M_select, 0);
    end
    OPB_MGrant  = 1'b1;
    OPB_xferAck = 1'b1;
    OPB_retry   = 1'b1;
    run_to_select(10);
    check("ackrty_be", M_BE, 4'h1);
    check("ackrty_dbus", M_DBus, 32'h0F0F_0F0F);
    tick();
    check("ackrty_rsp_valid", rsp_valid, 1);
    check("ackrty_status", rsp_status, 0);
    check("ackrty_wr_rdata_zero", rsp_rdata, 0);
    slave_idle();
    tick();

    // errAck together with xferAck and retry
    OPB_MGrant  = 1'b1;
    OPB_errAck  = 1'b1;
    OPB_xferAck = 1'b1;
    OPB_retry   = 1'b1;
    OPB_DBus    = 32'hAAAA_5555;
    issue(1'b1, 32'h0000_0400, 4'hF, 32'h0);
    wait_rsp(20, sel_cycles, sel_phases);
    check("err_status", rsp_status, 1);
    check("err_sel_cycles", sel_cycles, 1);
    check("err_rdata_held", rsp_rdata, 0);
    slave_idle();
    tick();

    // Reset during XFER drops the bus immediately and yields no response
    OPB_MGrant = 1'b1;
    issue(1'b0, 32'h0000_0500, 4'hF, 32'h1122_3344);
    run_to_select(10);
    check("rstx_pre_dbus", M_DBus, 32'h1122_3344);
    #2 OPB_Rst_n = 1'b0;
    #1;
    check("rstx_select", M_select, 0);
    check("rstx_request", M_request, 0);
    check("rstx_dbus", M_DBus, 0);
    check("rstx_rsp_valid", rsp_valid, 0);
    tick();
    OPB_Rst_n = 1'b1;
    repeat (4) begin
      tick();
      check("rstx_no_rsp", rsp_valid, 0);
    end
    check("rstx_ready", cmd_ready, 1);
    slave_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
